hssl_rx_frame_decoder: RTL

- Consumes the 32-bit 8b/10b-decoded receive stream of the HSSL gigabit transceiver: data, K-flags, disparity and encoding errors.
- Tracks link word sync against idle words and strips idles.
- Buffers payload words in a small FIFO with a valid/ready output toward the SpiNNaker packet path.
- Reports sync state plus saturating error and drop counters.
- Runs entirely in the rx_usrclk2 domain.

---
 rtl/hssl_rx_frame_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hssl_rx_frame_decoder.sv
// HSSL receive-side frame decoder: word-sync tracking against K28.5 idles,
// idle stripping, payload FIFO with valid/ready output, saturating error/drop counters.
module hssl_rx_frame_decoder #(
    parameter int unsigned SYNC_IDLES = 16,
    parameter int unsigned LOSS_BADS  = 4,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        rx_reset_done_in,
    input  logic [31:0] rx_data_in,
    input  logic [3:0]  rx_charisk_in,
    input  logic [3:0]  rx_disperr_in,
    input  logic [3:0]  rx_encerr_in,
    output logic [31:0] dat_out,
    output logic        vld_out,
    input  logic        rdy_in,
    output logic        synced_out,
    output logic [15:0] err_cnt_out,
    output logic [15:0] drop_cnt_out,
    input  logic        cnt_clear_in
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned IW = $clog2(SYNC_IDLES + 1);
    localparam int unsigned BW = $clog2(LOSS_BADS + 1);

    localparam logic [1:0] ST_LOS    = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_SYNCED = 2'd2;

    logic [31:0]   s1_data_q;
    logic [3:0]    s1_k_q, s1_derr_q, s1_eerr_q;
    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [BW-1:0] bad_q, bad_d;
    logic          synced_q;
    logic [15:0]   err_cnt_q, drop_cnt_q;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic          is_idle, is_data, is_bad, s1_err;
    logic          push, err_inc, full, pop, push_ok, drop;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            s1_data_q <= '0;
            s1_k_q    <= '0;
            s1_derr_q <= '0;
            s1_eerr_q <= '0;
        end else begin
            s1_data_q <= rx_data_in;
            s1_k_q    <= rx_charisk_in;
            s1_derr_q <= rx_disperr_in;
            s1_eerr_q <= rx_encerr_in;
        end
    end

    assign s1_err  = (|s1_derr_q) | (|s1_eerr_q);
    assign is_idle = !s1_err && (s1_k_q == 4'b0001) && (s1_data_q[7:0] == 8'hBC);
    assign is_data = !s1_err && (s1_k_q == 4'b0000);
    assign is_bad  = !is_idle && !is_data;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        bad_d   = bad_q;
        push    = 1'b0;
        err_inc = 1'b0;
        if (!rx_reset_done_in) begin
            state_d = ST_LOS;
            idle_d  = '0;
            bad_d   = '0;
        end else begin
            case (state_q)
                ST_LOS: begin
                    if (is_idle) begin
                        state_d = ST_CHECK;
                        idle_d  = IW'(1);
                    end
                end
                ST_CHECK: begin
                    if (is_idle) begin
                        if (idle_q == IW'(SYNC_IDLES - 1)) begin
                            state_d = ST_SYNCED;
                            idle_d  = '0;
                        end else begin
                            idle_d = idle_q + IW'(1);
                        end
                    end else if (is_bad) begin
                        state_d = ST_LOS;
                        idle_d  = '0;
                    end
                end
                ST_SYNCED: begin
                    if (is_bad) begin
                        err_inc = 1'b1;
                        if (bad_q == BW'(LOSS_BADS - 1)) begin
                            state_d = ST_LOS;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + BW'(1);
                        end
                    end else begin
                        bad_d = '0;
                        push  = is_data;
                    end
                end
                default: begin
                    state_d = ST_LOS;
                    idle_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end
    end

    // Extra MSB on the pointers distinguishes full from empty when the indices match.
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign vld_out = (wr_q != rd_q);
    assign dat_out = vld_out ? mem_q[rd_q[AW-1:0]] : '0;
    assign pop     = vld_out && rdy_in;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= s1_data_q;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= ST_LOS;
            idle_q     <= '0;
            bad_q      <= '0;
            synced_q   <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            bad_q    <= bad_d;
            synced_q <= (state_d == ST_SYNCED);
            if (!rx_reset_done_in) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push_ok) wr_q <= wr_q + (AW+1)'(1);
                if (pop)     rd_q <= rd_q + (AW+1)'(1);
            end
            if (cnt_clear_in)                      err_cnt_q <= '0;
            else if (err_inc && err_cnt_q != '1)   err_cnt_q <= err_cnt_q + 16'd1;
            if (cnt_clear_in)                      drop_cnt_q <= '0;
            else if (drop && drop_cnt_q != '1)     drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign synced_out   = synced_q;
    assign err_cnt_out  = err_cnt_q;
    assign drop_cnt_out = drop_cnt_q;

endmodule
